// File: rtl/oled_pkg.sv
// Shared OLED framebuffer geometry and the rectangle-fill state encoding.
package oled_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int PIX_IDX_W = 13;
    localparam int COLOUR_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rect_fill_writer_xy_to_index.sv
// Screen (x,y) to linear framebuffer index for a 96-wide screen, built from
// shifts and adds: y*96 = (y<<6) + (y<<5).
module xy_to_index
    import oled_pkg::*;
#(
    parameter int IDX_W = PIX_IDX_W
) (
    input  logic [6:0]       x,
    input  logic [5:0]       y,
    output logic [IDX_W-1:0] row_base,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] y_ext;

    always_comb begin
        y_ext    = IDX_W'(y);
        row_base = (y_ext << 6) + (y_ext << 5);
        index    = row_base + IDX_W'(x);
    end

endmodule

// File: rtl/rect_fill_writer.sv
// Rectangle fill: turns a clipped screen-space rectangle into a raster-ordered
// stream of framebuffer writes with a valid/ready write port.
module rect_fill_writer #(
    parameter int SCR_W    = oled_pkg::OLED_W,
    parameter int SCR_H    = oled_pkg::OLED_H,
    parameter int IDX_W    = oled_pkg::PIX_IDX_W,
    parameter int COLOUR_W = oled_pkg::COLOUR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_x,
    input  logic [6:0]          cmd_y,
    input  logic [7:0]          cmd_w,
    input  logic [6:0]          cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic                wr_en,
    input  logic                wr_ready,
    output logic [IDX_W-1:0]    wr_addr,
    output logic [COLOUR_W-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output oled_pkg::state_e    dbg_state
);

    // Handshakes: a command is taken when cmd_valid && cmd_ready at a rising
    // edge; a pixel moves when wr_en && wr_ready at a rising edge, and while
    // wr_en is high without wr_ready the address and data stay put.

    oled_pkg::state_e    state_q, state_d;
    logic [6:0]          x_start_q, x_start_d;
    logic [6:0]          x_end_q, x_end_d;
    logic [6:0]          y_end_q, y_end_d;
    logic [6:0]          cur_x_q, cur_x_d;
    logic [6:0]          cur_y_q, cur_y_d;
    logic [IDX_W-1:0]    row_base_q, row_base_d;
    logic [IDX_W-1:0]    wr_addr_q, wr_addr_d;
    logic [COLOUR_W-1:0] wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;

    logic [8:0]          cmd_x_sum;
    logic [7:0]          cmd_y_sum;
    logic [6:0]          cmd_x_end;
    logic [6:0]          cmd_y_end;
    logic                cmd_degenerate;
    logic [IDX_W-1:0]    cmd_row_base;
    logic [IDX_W-1:0]    cmd_index;
    logic                last_col;
    logic                last_row;

    xy_to_index #(
        .IDX_W(IDX_W)
    ) u_xy_to_index (
        .x        (cmd_x[6:0]),
        .y        (cmd_y[5:0]),
        .row_base (cmd_row_base),
        .index    (cmd_index)
    );

    // Sums are one bit wider than their operands so x+w up to 510 clips correctly.
    always_comb begin
        cmd_x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
        cmd_y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};
        cmd_x_end = (cmd_x_sum > 9'(SCR_W)) ? 7'(SCR_W) : cmd_x_sum[6:0];
        cmd_y_end = (cmd_y_sum > 8'(SCR_H)) ? 7'(SCR_H) : cmd_y_sum[6:0];
        cmd_degenerate = (cmd_x >= 8'(SCR_W)) || (cmd_y >= 7'(SCR_H)) ||
                         (cmd_w == 8'd0) || (cmd_h == 7'd0);
        last_col = (7'(cur_x_q + 7'd1) == x_end_q);
        last_row = (7'(cur_y_q + 7'd1) == y_end_q);
    end

    always_comb begin
        state_d    = state_q;
        x_start_d  = x_start_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = wr_en_q;
        done_d     = 1'b0;

        case (state_q)
            oled_pkg::IDLE: begin
                if (cmd_valid) begin
                    if (cmd_degenerate) begin
                        state_d = oled_pkg::DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = oled_pkg::FILL;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = cmd_index;
                        wr_data_d  = cmd_colour;
                        x_start_d  = cmd_x[6:0];
                        cur_x_d    = cmd_x[6:0];
                        cur_y_d    = cmd_y;
                        row_base_d = cmd_row_base;
                        x_end_d    = cmd_x_end;
                        y_end_d    = cmd_y_end;
                    end
                end
            end
            oled_pkg::FILL: begin
                if (wr_ready) begin
                    if (last_col && last_row) begin
                        state_d = oled_pkg::DONE;
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (last_col) begin
                        cur_x_d    = x_start_q;
                        cur_y_d    = 7'(cur_y_q + 7'd1);
                        row_base_d = row_base_q + IDX_W'(SCR_W);
                        wr_addr_d  = row_base_q + IDX_W'(SCR_W) + IDX_W'(x_start_q);
                    end else begin
                        cur_x_d   = 7'(cur_x_q + 7'd1);
                        wr_addr_d = wr_addr_q + IDX_W'(1);
                    end
                end
            end
            oled_pkg::DONE: begin
                state_d = oled_pkg::IDLE;
            end
            default: begin
                state_d = oled_pkg::IDLE;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= oled_pkg::IDLE;
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_start_q  <= x_start_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready = (state_q == oled_pkg::IDLE);
    assign busy      = (state_q != oled_pkg::IDLE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer: reset, single pixel, clipping,
// backpressure, degenerate commands, full screen and mid-fill reset.
module tb_rect_fill_writer;
    import oled_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [15:0] cmd_colour;
    logic        wr_en;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    state_e      dbg_state;

    int tests = 0;
    int fails = 0;
    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    int busy_cycles;
    int done_cycles;
    int data_errs;

    always #5 clk = ~clk;

    rect_fill_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, then runs until the block returns to idle. Collects
    // every transferred address; optionally stalls the write port after
    // stall_after transfers, or asserts reset once rst_at transfers are done.
    task automatic do_cmd(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                          input logic [6:0] h, input logic [15:0] col,
                          input int stall_after, input int stall_len, input int rst_at);
        int  stall_cnt;
        bit  finished;
        got_q.delete();
        busy_cycles = 0;
        done_cycles = 0;
        data_errs   = 0;
        stall_cnt   = 0;
        finished    = 1'b0;
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_colour = col;
        cmd_valid = 1'b1;
        wr_ready  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (rst_at >= 0 && got_q.size() == rst_at) begin
                check("pre_rst_wr_en", wr_en, 1);
                rst_n = 1'b0;
                #1;
                check("midrst_wr_en", wr_en, 0);
                check("midrst_busy", busy, 0);
                check("midrst_done", done, 0);
                check("midrst_cmd_ready", cmd_ready, 1);
                check("midrst_wr_addr", wr_addr, 0);
                finished = 1'b1;
                break;
            end
            busy_cycles++;
            if (done) done_cycles++;
            if (stall_cnt > 0) begin
                wr_ready = 1'b0;
                stall_cnt--;
                check("stall_wr_en", wr_en, 1);
                if (got_q.size() < exp_q.size())
                    check("stall_hold_addr", wr_addr, exp_q[got_q.size()]);
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_en && wr_ready) begin
                got_q.push_back(wr_addr);
                if (wr_data !== col) data_errs++;
                if (got_q.size() == stall_after) stall_cnt = stall_len;
            end
            tick();
        end
        if (!finished) check("cmd_timeout_busy", busy, 0);
        wr_ready = 1'b1;
    endtask

    task automatic compare_seq(input string tag);
        int n;
        check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_addr[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; wr_ready = 1'b1;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;

        // Reset values
        #3;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_state", dbg_state, IDLE);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single pixel with exact cycle timing; cmd_valid kept high while busy
        cmd_x = 8'd5; cmd_y = 7'd2; cmd_w = 8'd1; cmd_h = 7'd1; cmd_colour = 16'hF800;
        cmd_valid = 1'b1;
        tick();
        check("px_cmd_ready", cmd_ready, 0);
        check("px_wr_en", wr_en, 1);
        check("px_wr_addr", wr_addr, 197);
        check("px_wr_data", wr_data, 16'hF800);
        check("px_busy", busy, 1);
        check("px_done_early", done, 0);
        cmd_x = 8'd50; cmd_colour = 16'h1234;
        tick();
        check("px_wr_en_after", wr_en, 0);
        check("px_done", done, 1);
        check("px_busy_done", busy, 1);
        check("px_cmd_ready_done", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        check("px_idle_done", done, 0);
        check("px_idle_busy", busy, 0);
        check("px_idle_ready", cmd_ready, 1);
        tick();
        check("px_ignored_wr_en", wr_en, 0);
        check("px_ignored_busy", busy, 0);

        // Bottom-right corner clip
        exp_q = '{13'd6046, 13'd6047, 13'd6142, 13'd6143};
        do_cmd(8'd94, 7'd62, 8'd4, 7'd4, 16'h07E0, -1, 0, -1);
        compare_seq("corner");
        check("corner_done_cycles", done_cycles, 1);
        check("corner_data_errs", data_errs, 0);

        // Width overflowing 8 bits clips to the right edge
        exp_q = '{13'd570, 13'd571, 13'd572, 13'd573, 13'd574, 13'd575};
        do_cmd(8'd90, 7'd5, 8'd200, 7'd1, 16'hABCD, -1, 0, -1);
        compare_seq("wide");
        check("wide_busy_cycles", busy_cycles, 7);

        // Backpressure: 3 stalled cycles after the second write
        exp_q = '{13'd970, 13'd971, 13'd972, 13'd1066, 13'd1067, 13'd1068};
        do_cmd(8'd10, 7'd10, 8'd3, 7'd2, 16'h001F, 2, 3, -1);
        compare_seq("bp");
        check("bp_busy_cycles", busy_cycles, 10);
        check("bp_done_cycles", done_cycles, 1);
        check("bp_data_errs", data_errs, 0);

        // Degenerate x=96: done in N+1, ready in N+2
        cmd_x = 8'd96; cmd_y = 7'd0; cmd_w = 8'd4; cmd_h = 7'd4; cmd_colour = 16'hFFFF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("degx_done", done, 1);
        check("degx_wr_en", wr_en, 0);
        check("degx_cmd_ready", cmd_ready, 0);
        tick();
        check("degx_ready_back", cmd_ready, 1);
        check("degx_done_clear", done, 0);
        check("degx_wr_en2", wr_en, 0);

        // Degenerate w=0, y=64, h=0
        exp_q.delete();
        do_cmd(8'd3, 7'd3, 8'd0, 7'd3, 16'h5555, -1, 0, -1);
        compare_seq("degw");
        check("degw_busy_cycles", busy_cycles, 1);
        check("degw_done_cycles", done_cycles, 1);
        do_cmd(8'd3, 7'd64, 8'd3, 7'd3, 16'h5555, -1, 0, -1);
        compare_seq("degy");
        do_cmd(8'd3, 7'd3, 8'd3, 7'd0, 16'h5555, -1, 0, -1);
        compare_seq("degh");

        // Full screen
        exp_q.delete();
        for (int i = 0; i < 6144; i++) exp_q.push_back(13'(i));
        do_cmd(8'd0, 7'd0, 8'd96, 7'd64, 16'hC0DE, -1, 0, -1);
        compare_seq("full");
        check("full_busy_cycles", busy_cycles, 6145);
        check("full_done_cycles", done_cycles, 1);
        check("full_data_errs", data_errs, 0);

        // Full screen again, reset after 3000 writes
        do_cmd(8'd0, 7'd0, 8'd96, 7'd64, 16'hBEEF, -1, 0, 3000);
        check("rstfill_writes", got_q.size(), 3000);
        check("rstfill_done_cycles", done_cycles, 0);
        tick(); tick();
        check("rstfill_held_wr_en", wr_en, 0);
        rst_n = 1'b1;
        tick();

        // New command after reset release
        exp_q = '{13'd308};
        do_cmd(8'd20, 7'd3, 8'd1, 7'd1, 16'h0F0F, -1, 0, -1);
        compare_seq("post_rst");
        check("post_rst_done_cycles", done_cycles, 1);
        check("post_rst_data_errs", data_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
